// File: rtl/board_ctrl_if.sv
// board_ctrl_if: button/event inputs and clk_en/sys_rst/led outputs of board_ctrl
interface board_ctrl_if #(
  parameter int NCH = 3
);
  logic           usr_btn;
  logic [NCH-1:0] evt;
  logic           clk_en;
  logic           sys_rst;
  logic [NCH-1:0] led;
  modport master (output usr_btn, evt, input clk_en, sys_rst, led);
  modport slave  (input usr_btn, evt, output clk_en, sys_rst, led);
endinterface

// File: rtl/board_ctrl.sv
// board_ctrl: clock-enable divider, debounced button reset sequencer and per-channel event counters driving LEDs (PWM LEDs when BOARD_CTRL_PWM_EN is defined)
module board_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int DEBOUNCE    = 16,
  parameter int RST_HOLD    = 8,
  parameter int NCH         = 3,
  parameter int CNT_W       = 32,
  parameter int TAP         = 20,
  parameter bit LED_ACT_LOW = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  board_ctrl_if.slave bus
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam int HW = $clog2(RST_HOLD + 1);
  typedef enum logic [1:0] {RUN, ASSERT, HOLD} state_t;
  logic [DW-1:0]    div_q, div_d;
  logic             clk_en;
  logic [1:0]       sync_q;
  logic             btn_db;
  logic [SW-1:0]    stab;
  state_t           state, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             sys_rst;
  logic [CNT_W-1:0] cnt [NCH];
  logic [NCH-1:0]   led;
  assign div_d = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
  assign sys_rst = (state != RUN);
  assign bus.clk_en = clk_en;
  assign bus.sys_rst = sys_rst;
  assign bus.led = led;
  // divider; clk_en is registered so it is 0 in reset even when CLK_DIV=1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      clk_en <= 1'b0;
    end else begin
      div_q <= div_d;
      clk_en <= (div_d == DW'(CLK_DIV - 1));
    end
  end
  // two-flop synchroniser followed by a consecutive-sample debouncer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      btn_db <= 1'b1;
      stab <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.usr_btn};
      if (sync_q[1] == btn_db)
        stab <= '0;
      else if (stab == SW'(DEBOUNCE - 1)) begin
        btn_db <= sync_q[1];
        stab <= '0;
      end else
        stab <= stab + SW'(1);
    end
  end
  // reset sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ASSERT;
      hold_q <= '0;
    end else begin
      state <= state_d;
      hold_q <= hold_d;
    end
  end
  // sequencer moves only on clk_en so sys_rst always spans whole enable periods
  always_comb begin
    state_d = state;
    hold_d = hold_q;
    if (clk_en)
      unique case (state)
        RUN:    state_d = btn_db ? RUN : ASSERT;
        ASSERT: begin
          state_d = btn_db ? HOLD : ASSERT;
          hold_d = '0;
        end
        HOLD:   begin
          state_d = !btn_db ? ASSERT : (hold_q == HW'(RST_HOLD - 1)) ? RUN : HOLD;
          hold_d = hold_q + HW'(1);
        end
        default: state_d = ASSERT;
      endcase
  end
  // event counters: count on enabled cycles, clear while downstream reset is held
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (!rst_n)
        cnt[i] <= '0;
      else if (clk_en)
        cnt[i] <= sys_rst ? '0 : cnt[i] + CNT_W'(bus.evt[i]);
  end
`ifdef BOARD_CTRL_PWM_EN
  logic [3:0] ramp;
  // free-running PWM ramp stepped by clk_en
  always_ff @(posedge clk) begin
    if (!rst_n)
      ramp <= '0;
    else if (clk_en)
      ramp <= ramp + 4'd1;
  end
  // LED brightness follows the four counter bits ending at TAP
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      led[i] <= !rst_n ? LED_ACT_LOW : (ramp < cnt[i][TAP -: 4]) ^ LED_ACT_LOW;
  end
`else
  // LED blinks with counter bit TAP
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      led[i] <= !rst_n ? LED_ACT_LOW : cnt[i][TAP] ^ LED_ACT_LOW;
  end
`endif
endmodule

// File: tb/tb_board_ctrl.sv
// tb_board_ctrl: randomized board_ctrl bench checked every cycle against a behavioural model
module tb_board_ctrl;
  localparam int CLK_DIV = 2, DEBOUNCE = 16, RST_HOLD = 8, NCH = 3, CNT_W = 8, TAP = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int k, s0, s1, db, run_len, mode, ticks, ramp, en, sr;
  int cnt [NCH];
  int led [NCH];
  board_ctrl_if #(.NCH(NCH)) bus ();
  board_ctrl #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .RST_HOLD(RST_HOLD), .NCH(NCH),
    .CNT_W(CNT_W), .TAP(TAP), .LED_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_step();
    int psr;
    if (!rst_n) begin
      k = 0; s0 = 1; s1 = 1; db = 1; run_len = 0; mode = 1; ticks = 0; ramp = 0;
      for (int n = 0; n < NCH; n++) begin
        cnt[n] = 0;
        led[n] = 1;
      end
    end else begin
      psr = (mode != 0) ? 1 : 0;
      for (int n = 0; n < NCH; n++) begin
`ifdef BOARD_CTRL_PWM_EN
        led[n] = (ramp < ((cnt[n] >> (TAP - 3)) % 16) ? 1 : 0) ^ 1;
`else
        led[n] = ((cnt[n] >> TAP) % 2) ^ 1;
`endif
        if (en != 0)
          cnt[n] = (psr != 0) ? 0 : (cnt[n] + int'(bus.evt[n])) % (1 << CNT_W);
      end
      if (en != 0) begin
        ramp = (ramp + 1) % 16;
        if (mode == 0) begin
          if (db == 0) mode = 1;
        end else if (mode == 1) begin
          if (db != 0) begin
            mode = 2;
            ticks = 0;
          end
        end else if (db == 0)
          mode = 1;
        else begin
          ticks++;
          if (ticks == RST_HOLD) mode = 0;
        end
      end
      if (s1 != db) begin
        run_len++;
        if (run_len == DEBOUNCE) begin
          db = s1;
          run_len = 0;
        end
      end else
        run_len = 0;
      s1 = s0;
      s0 = int'(bus.usr_btn);
      k++;
    end
    en = (k > 0 && k % CLK_DIV == CLK_DIV - 1) ? 1 : 0;
    sr = (mode != 0) ? 1 : 0;
  endtask
  task automatic cyc(input logic btn, input logic [NCH-1:0] e);
    bus.usr_btn = btn;
    bus.evt = e;
    @(posedge clk);
    model_step();
    #1;
    chk("clk_en", 32'(bus.clk_en), en);
    chk("sys_rst", 32'(bus.sys_rst), sr);
    chk("btn_db", 32'(dut.btn_db), db);
    for (int n = 0; n < NCH; n++) begin
      chk($sformatf("cnt%0d", n), 32'(dut.cnt[n]), cnt[n]);
      chk($sformatf("led%0d", n), 32'(bus.led[n]), led[n]);
    end
  endtask
  task automatic run(input int nc, input logic btn, input int evt_mode);
    logic [NCH-1:0] e;
    for (int c = 0; c < nc; c++) begin
      e = evt_mode == 1 ? NCH'($urandom) :
          evt_mode == 2 ? (en == 0 ? '1 : '0) :
          evt_mode == 3 ? (en != 0 ? '1 : '0) : '0;
      cyc(btn, e);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    run(4, 1'b1, 1);
    rst_n = 1'b1;
    run(60, 1'b1, 0);
    run(10, 1'b0, 0);
    run(40, 1'b1, 0);
    run(40, 1'b0, 0);
    run(60, 1'b1, 0);
    run(70, 1'b1, 3);
    run(200, 1'b1, 2);
    run(600, 1'b1, 1);
    run(500, 1'b1, 3);
    run(40, 1'b0, 1);
    run(26, 1'b1, 1);
    rst_n = 1'b0;
    run(1, 1'b1, 1);
    rst_n = 1'b1;
    run(60, 1'b1, 1);
    for (int r = 0; r < 30; r++)
      run(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)), 1);
    run(60, 1'b1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
